// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, grant-source
// tags, IF default byte enable and the command payload issued to memory.
package mem_arb_pkg;

    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_DM = 2'd2
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    localparam logic [BEW-1:0] IF_BE = 4'hF;

    // Non-address part of a memory command (address width is a top parameter)
    typedef struct packed {
        logic           we;
        logic [BEW-1:0] be;
        logic [DW-1:0]  wdata;
    } mem_cmd_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-cycle counter for a bus master waiting on a slave ack.
// Ports: clk, rst_n (async active-low); clear zeroes the count; enable
// advances it (saturating); expired flags the last allowed wait cycle.
// TIMEOUT=0 disables expiry.
module arb_wait_timer #(
    parameter int unsigned TO_WIDTH = 8,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_WIDTH-1:0] LAST = TO_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [TO_WIDTH-1:0] cnt;

    // Saturating wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != '1)) begin
            cnt <= cnt + TO_WIDTH'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (read-only) and
// data access (read/write). DM has priority unless IF has been passed over
// STARVE_MAX times in a row; every transaction is bounded by a wait timeout.
// Ports: CLK, RESET (async active-low); if_* fetch handshake; dm_* data
// handshake; mem_* memory request/response; busy high while not IDLE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned TO_WIDTH   = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    output logic            if_err,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [BEW-1:0]  dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_ack,
    output logic            dm_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [BEW-1:0]  mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic            busy
);

    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t          state, state_d;
    mem_cmd_t        cmd_q, cmd_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            req_q, req_d;
    logic [DW-1:0]   if_rdata_d, dm_rdata_d;
    logic            if_ack_d, if_err_d, dm_ack_d, dm_err_d;
    logic [SW-1:0]   starve, starve_d;
    logic            expired;
    logic            ack_cycle;
    logic            owner;

    arb_wait_timer #(
        .TO_WIDTH (TO_WIDTH),
        .TIMEOUT  (TIMEOUT)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (RESET),
        .clear   (state_d == IDLE),
        .enable  (state != IDLE),
        .expired (expired)
    );

    // No grant while any ack is pulsing, so a stale req cannot re-issue
    assign ack_cycle = if_ack | dm_ack;
    assign owner     = (state == WAIT_DM) ? GNT_DM : GNT_IF;

    // Next-state, arbitration and completion routing
    always_comb begin
        state_d    = state;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        req_d      = req_q;
        if_rdata_d = if_rdata;
        dm_rdata_d = dm_rdata;
        if_ack_d   = 1'b0;
        if_err_d   = 1'b0;
        dm_ack_d   = 1'b0;
        dm_err_d   = 1'b0;
        starve_d   = starve;

        case (state)
            IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (!ack_cycle) begin
                    if (dm_req && !(if_req && (starve == STARVE_LIM))) begin
                        state_d     = WAIT_DM;
                        req_d       = 1'b1;
                        addr_d      = dm_addr;
                        cmd_d.we    = dm_we;
                        cmd_d.be    = dm_be;
                        cmd_d.wdata = dm_wdata;
                        if (if_req && (starve != STARVE_LIM)) begin
                            starve_d = starve + SW'(1);
                        end
                    end else if (if_req) begin
                        state_d     = WAIT_IF;
                        req_d       = 1'b1;
                        addr_d      = if_addr;
                        cmd_d.we    = 1'b0;
                        cmd_d.be    = IF_BE;
                        cmd_d.wdata = '0;
                        starve_d    = '0;
                    end
                end
            end
            WAIT_IF, WAIT_DM: begin
                // Ack takes precedence over a same-cycle timeout
                if (mem_ack || expired) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    if (owner == GNT_IF) begin
                        if_ack_d = 1'b1;
                        if_err_d = !mem_ack;
                        if (mem_ack) begin
                            if_rdata_d = mem_rdata;
                        end
                    end else begin
                        dm_ack_d = 1'b1;
                        dm_err_d = !mem_ack;
                        if (mem_ack && !cmd_q.we) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            cmd_q    <= '0;
            addr_q   <= '0;
            req_q    <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            dm_ack   <= 1'b0;
            dm_err   <= 1'b0;
            starve   <= '0;
        end else begin
            state    <= state_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            if_rdata <= if_rdata_d;
            dm_rdata <= dm_rdata_d;
            if_ack   <= if_ack_d;
            if_err   <= if_err_d;
            dm_ack   <= dm_ack_d;
            dm_err   <= dm_err_d;
            starve   <= starve_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = cmd_q.we;
    assign mem_be    = cmd_q.be;
    assign mem_wdata = cmd_q.wdata;
    assign mem_addr  = addr_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, simultaneous
// requests, starvation guard, timeout and ack/timeout collision.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack, if_err;
    logic        dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_ack, dm_err;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .AW(32), .STARVE_MAX(3), .TIMEOUT(16), .TO_WIDTH(8)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Bounded wait for mem_req; an expired bound shows up as a failed check
    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 10) begin
            step();
            n++;
        end
        chk(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {26'd0, mem_req, mem_we, if_ack, if_err, dm_ack, dm_err}, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_be"}, 32'(mem_be), 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    endtask

    initial begin
        int hi;
        logic [31:0] exp_addr [5];
        exp_addr[0] = 32'h300; exp_addr[1] = 32'h300; exp_addr[2] = 32'h300;
        exp_addr[3] = 32'h400; exp_addr[4] = 32'h300;

        RESET = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;

        // Reset state
        step(); step();
        chk_all_zero("reset");
        RESET = 1'b1;
        step();

        // Single IF read, one wait cycle
        if_req = 1'b1; if_addr = 32'h10;
        step();
        chk("if1_req", 32'(mem_req), 32'd1);
        chk("if1_we", 32'(mem_we), 32'd0);
        chk("if1_be", 32'(mem_be), 32'hF);
        chk("if1_addr", mem_addr, 32'h10);
        chk("if1_busy", 32'(busy), 32'd1);
        step();
        chk("if1_req2", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
        step();
        mem_ack = 1'b0; if_req = 1'b0;
        chk("if1_ack", 32'(if_ack), 32'd1);
        chk("if1_err", 32'(if_err), 32'd0);
        chk("if1_rdata", if_rdata, 32'h2008_0005);
        chk("if1_req_drop", 32'(mem_req), 32'd0);
        chk("if1_busy_drop", 32'(busy), 32'd0);
        step();
        chk("if1_ack_once", 32'(if_ack), 32'd0);

        // Reset mid-transaction, then a late ack
        if_req = 1'b1; if_addr = 32'h40;
        step();
        chk("rst_mid_req", 32'(mem_req), 32'd1);
        step();
        #2 RESET = 1'b0; if_req = 1'b0;
        #1 chk_all_zero("rst_mid");
        step();
        RESET = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        chk("rst_late_ack", 32'(if_ack), 32'd0);
        chk("rst_late_req", 32'(mem_req), 32'd0);
        chk("rst_late_busy", 32'(busy), 32'd0);
        chk("rst_late_rdata", if_rdata, 32'd0);
        step();

        // Simultaneous requests: DM write first, then IF
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h100; dm_wdata = 32'hCAFE_F00D;
        step();
        chk("sim_dm_req", 32'(mem_req), 32'd1);
        chk("sim_dm_we", 32'(mem_we), 32'd1);
        chk("sim_dm_be", 32'(mem_be), 32'h3);
        chk("sim_dm_addr", mem_addr, 32'h100);
        chk("sim_dm_wdata", mem_wdata, 32'hCAFE_F00D);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0; dm_req = 1'b0;
        chk("sim_dm_ack", 32'(dm_ack), 32'd1);
        chk("sim_dm_err", 32'(dm_err), 32'd0);
        chk("sim_dm_rdata", dm_rdata, 32'd0);
        chk("sim_gap0", 32'(mem_req), 32'd0);
        step();
        chk("sim_gap1", 32'(mem_req), 32'd0);
        chk("sim_dm_ack_once", 32'(dm_ack), 32'd0);
        step();
        chk("sim_if_req", 32'(mem_req), 32'd1);
        chk("sim_if_addr", mem_addr, 32'h200);
        chk("sim_if_we", 32'(mem_we), 32'd0);
        chk("sim_if_be", 32'(mem_be), 32'hF);
        chk("sim_if_wdata", mem_wdata, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_ack = 1'b0; if_req = 1'b0;
        chk("sim_if_ack", 32'(if_ack), 32'd1);
        chk("sim_if_rdata", if_rdata, 32'h1111_2222);
        chk("sim_dm_rdata_kept", dm_rdata, 32'd0);
        step(); step();

        // Starvation guard: DM,DM,DM,IF,DM
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h300; dm_wdata = '0;
        for (int k = 0; k < 5; k++) begin
            wait_req($sformatf("starve_wait%0d", k));
            chk($sformatf("starve_gnt%0d", k), mem_addr, exp_addr[k]);
            mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + 32'(k);
            step();
            mem_ack = 1'b0;
        end
        if_req = 1'b0; dm_req = 1'b0;
        step();
        chk("starve_dm_rdata", dm_rdata, 32'hA000_0004);
        chk("starve_if_rdata", if_rdata, 32'hA000_0003);
        step();

        // Timeout on a DM read that never acks
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500; mem_rdata = 32'hBAD0_BAD0;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dm_ack) break;
            if (mem_req) hi++;
        end
        dm_req = 1'b0;
        chk("to_req_cycles", 32'(hi), 32'd16);
        chk("to_ack", 32'(dm_ack), 32'd1);
        chk("to_err", 32'(dm_err), 32'd1);
        chk("to_rdata_kept", dm_rdata, 32'hA000_0004);
        chk("to_req_drop", 32'(mem_req), 32'd0);
        if_req = 1'b1; if_addr = 32'h600;
        step();
        chk("to_ack_once", 32'({dm_ack, dm_err}), 32'd0);
        wait_req("to_if_wait");
        chk("to_if_addr", mem_addr, 32'h600);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0; if_req = 1'b0;
        chk("to_if_ack", 32'(if_ack), 32'd1);
        chk("to_if_err", 32'(if_err), 32'd0);
        chk("to_if_rdata", if_rdata, 32'h1234_5678);
        step(); step();

        // mem_ack in the 16th wait cycle wins over timeout
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h700; mem_rdata = 32'hBAD0_BAD0;
        wait_req("col_wait");
        repeat (15) step();
        chk("col_req_16th", 32'(mem_req), 32'd1);
        chk("col_no_early_ack", 32'(dm_ack), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h5A5A_1234;
        step();
        mem_ack = 1'b0; dm_req = 1'b0;
        chk("col_ack", 32'(dm_ack), 32'd1);
        chk("col_err", 32'(dm_err), 32'd0);
        chk("col_rdata", dm_rdata, 32'h5A5A_1234);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares one single-ported unified memory between two requesters: instruction fetch (IF, read-only) and data memory access (DM, read/write).
- Sits between the MIPS core's fetch/load-store paths and the memory model.
- Provides valid/ack handshakes to the core, DM-priority arbitration with an IF anti-starvation guard, and a per-transaction timeout.

Parameters:
AW, 32, address width in bits (byte address)
STARVE_MAX, 3, consecutive DM grants tolerated while if_req is pending before IF is forced to win
TIMEOUT, 16, maximum cycles spent waiting for mem_ack; 0 disables the timeout
TO_WIDTH, 8, width of the wait counter; TIMEOUT must be < 2^TO_WIDTH

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  AW  fetch address
if_rdata  out  32  fetched word; valid with if_ack, held until the next IF ack
if_ack  out  1  one-cycle completion pulse
if_err  out  1  pulses with if_ack when the transaction timed out
dm_req  in  1  data request; held with the dm_* fields until dm_ack
dm_we  in  1  1 = write, 0 = read
dm_be  in  4  byte enables for writes
dm_addr  in  AW  data address
dm_wdata  in  32  write data
dm_rdata  out  32  load data; valid with dm_ack on reads, held otherwise
dm_ack  out  1  one-cycle completion pulse
dm_err  out  1  pulses with dm_ack when the transaction timed out
mem_req  out  1  memory request; held until mem_ack or timeout
mem_we  out  1  memory write enable
mem_be  out  4  memory byte enables
mem_addr  out  AW  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data; valid when mem_ack=1
mem_ack  in  1  memory completion, one cycle
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; starve_cnt=0; wait_cnt=0.
  - All outputs 0, including both rdata registers.
  - A mem_ack arriving after reset deasserts is ignored.
- FSM states: IDLE, WAIT_IF, WAIT_DM.
- IDLE:
  - Winner selection:
    - dm_req && !(if_req && starve_cnt==STARVE_MAX) -> WAIT_DM.
    - else if_req -> WAIT_IF.
    - else stay in IDLE.
  - On the transition, register mem_req=1 and mem_addr/mem_we/mem_be/mem_wdata from the winner.
  - IF grants drive mem_we=0, mem_be=4'hF, mem_wdata=0.
  - mem_ack seen in IDLE is ignored.
- WAIT_x:
  - mem_req and all mem_* fields are held stable.
  - wait_cnt increments each cycle.
  - On mem_ack:
    - Next edge: drop mem_req, pulse x_ack=1 for one cycle, go to IDLE.
    - Reads capture mem_rdata into x_rdata; writes leave dm_rdata unchanged.
  - On wait_cnt==TIMEOUT-1 with no mem_ack (TIMEOUT!=0):
    - Next edge: drop mem_req, pulse x_ack=1 and x_err=1, go to IDLE.
    - x_rdata unchanged.
  - mem_ack and timeout in the same cycle: ack wins, err=0.
  - wait_cnt clears on leaving WAIT.
- Latency:
  - Request sampled in IDLE at edge N -> mem_req=1 from N.
  - mem_ack sampled at edge M -> ack pulse during cycle M..M+1.
  - Minimum request-to-ack latency is 2 cycles with zero-wait memory.
- Handshake:
  - A requester's req is ignored during the cycle its ack is high, so a stale req cannot double-issue.
  - Back-to-back transactions: the next mem_req rises one cycle after the previous ack pulse (one IDLE cycle).
  - Dropping req while granted does not abort the transaction; it completes and acks.
- Starvation counter:
  - Increments on each DM grant while if_req=1, saturating at STARVE_MAX.
  - Clears on an IF grant or whenever if_req=0 in IDLE.
- Widths: counters saturate and never wrap. dm_be passes through unmodified; zero enables are legal and still complete.
- busy is combinational from state.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE=2'd0, WAIT_IF=2'd1, WAIT_DM=2'd2);
  - grant-source constants GNT_IF/GNT_DM;
  - IF default byte-enable 4'hF.
- Sub-module arb_wait_timer (TO_WIDTH, TIMEOUT):
  - inputs: clear, enable; output: expired;
  - also reused for other bus masters.

Test Plan:
- Reset mid-transaction:
  - Stimulus: IF read at 0x40, memory acks after 3 cycles; drop RESET during the 2nd wait cycle, then a late mem_ack arrives.
  - Required response: all outputs 0 immediately, state IDLE, no if_ack pulse.
- Single IF read:
  - Stimulus: if_addr=0x0000_0010, memory returns 0x2008_0005 with 1-cycle wait.
  - Required response: mem_req high 2 cycles, mem_we=0, mem_be=F, if_ack pulses once, if_rdata=0x2008_0005, busy falls with the ack.
- Simultaneous requests:
  - Stimulus: if_req and dm_req together, DM write addr 0x100, data 0xCAFE_F00D, be=4'b0011.
  - Required response: DM granted first with mem_we=1, mem_be=3; IF mem_req rises one cycle after dm_ack; dm_rdata unchanged.
- Starvation:
  - Stimulus: dm_req held continuously (reissued after each ack) and if_req held, STARVE_MAX=3, zero-wait memory.
  - Required response: grant sequence DM,DM,DM,IF,DM,...
- Timeout:
  - Stimulus: TIMEOUT=16, memory never acks a DM read.
  - Required response: mem_req high exactly 16 cycles; dm_ack=dm_err=1 one cycle; dm_rdata keeps its prior value; then an IF request is served normally.
- Ack/timeout collision:
  - Stimulus: mem_ack arrives in the 16th wait cycle.
  - Required response: ack with err=0 and captured rdata.
